// File: rtl/vliw_mem_pkg.sv
// Shared types and helpers for the banked VLIW data memory.
// Holds the sweep/burst FSM encoding and the lane rotation helper.
package vliw_mem_pkg;

    localparam int DEF_BEAT_BYTES  = 128;
    localparam int DEF_DEPTH_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BURST
    } state_t;

    // Lane reached by stepping 'off' lanes from 'lane' in an n-lane ring.
    function automatic int unsigned lane_rot(
        input int unsigned lane,
        input int unsigned off,
        input int unsigned n
    );
        return (lane + off) % n;
    endfunction

endpackage

// File: rtl/vliw_burst_ram_if.sv
// Read-burst and write-beat bus of the banked VLIW data memory.
// slave is the memory side, master the requester side.
interface vliw_burst_ram_if #(
    parameter int BEAT_BYTES = 128,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 4
);
    logic                    busy;
    logic                    rd_req_valid;
    logic                    rd_req_ready;
    logic [ADDR_W-1:0]       rd_adr;
    logic [LEN_W-1:0]        rd_len;
    logic                    rd_valid;
    logic [8*BEAT_BYTES-1:0] rd_data;
    logic                    rd_last;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_adr;
    logic [8*BEAT_BYTES-1:0] wr_data;
    logic [BEAT_BYTES-1:0]   wr_be;

    modport slave (
        output busy, rd_req_ready, rd_valid, rd_data, rd_last, wr_ready,
        input  rd_req_valid, rd_adr, rd_len,
        input  wr_valid, wr_adr, wr_data, wr_be
    );

    modport master (
        input  busy, rd_req_ready, rd_valid, rd_data, rd_last, wr_ready,
        output rd_req_valid, rd_adr, rd_len,
        output wr_valid, wr_adr, wr_data, wr_be
    );
endinterface

// File: rtl/vliw_ram_bank.sv
// One byte-wide bank: registered read, one write port, read-before-write.
// The storage array is deliberately unreset; the clear sweep initialises it.
module vliw_ram_bank #(
    parameter int ROWS  = 32,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             re,
    input  logic [ROW_W-1:0] raddr,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [7:0]       din,
    output logic [7:0]       dout
);
    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  dout <= '0;
        else if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/vliw_burst_ram.sv
// Banked byte-addressed VLIW data memory with unaligned burst reads,
// byte-enabled unaligned writes, bounds masking and a post-reset clear sweep.
module vliw_burst_ram
    import vliw_mem_pkg::*;
#(
    parameter int BEAT_BYTES  = DEF_BEAT_BYTES,
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int ADDR_W      = 16,
    parameter int LEN_W       = 4
) (
    input logic               clk_h,
    input logic               rst_n,
    vliw_burst_ram_if.slave   bus
);
    localparam int ROWS   = DEPTH_BYTES / BEAT_BYTES;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W = $clog2(BEAT_BYTES);
    localparam int AW1    = ADDR_W + 1;
    localparam int RF_W   = AW1 - LANE_W;

    state_t            state, state_n;
    logic [ROW_W-1:0]  clr_row, clr_row_n;
    logic [AW1-1:0]    bst_adr, bst_adr_n;
    logic [LEN_W-1:0]  bst_cnt, bst_cnt_n;
    logic              issue, last;
    logic [AW1-1:0]    iss_adr;
    logic              clr, wr_fire;

    assign clr          = (state == ST_CLEAR);
    assign wr_fire      = bus.wr_valid & ~clr;
    assign bus.busy     = clr;
    assign bus.wr_ready = ~clr;
    assign bus.rd_req_ready = (state == ST_IDLE);

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_row <= '0;
            bst_adr <= '0;
            bst_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_row <= clr_row_n;
            bst_adr <= bst_adr_n;
            bst_cnt <= bst_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_row_n = clr_row;
        bst_adr_n = bst_adr;
        bst_cnt_n = bst_cnt;
        issue     = 1'b0;
        last      = 1'b0;
        iss_adr   = '0;
        unique case (state)
            ST_CLEAR: begin
                clr_row_n = clr_row + 1'b1;
                if (clr_row == ROW_W'(ROWS - 1)) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.rd_req_valid) begin
                    issue   = 1'b1;
                    iss_adr = {1'b0, bus.rd_adr};
                    last    = (bus.rd_len == '0);
                    if (!last) begin
                        state_n   = ST_BURST;
                        bst_adr_n = iss_adr + AW1'(BEAT_BYTES);
                        bst_cnt_n = bus.rd_len;
                    end
                end
            end
            ST_BURST: begin
                issue     = 1'b1;
                iss_adr   = bst_adr;
                last      = (bst_cnt == LEN_W'(1));
                bst_adr_n = bst_adr + AW1'(BEAT_BYTES);
                bst_cnt_n = bst_cnt - 1'b1;
                if (last) state_n = ST_IDLE;
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    logic [LANE_W-1:0]     rlane, wlane, rd_lane;
    logic [BEAT_BYTES-1:0] iss_mask, rd_mask;
    logic [7:0]            dout  [BEAT_BYTES];
    logic [7:0]            wbyte [BEAT_BYTES];
    logic                  rd_valid, rd_last;

    assign rlane = iss_adr[LANE_W-1:0];
    assign wlane = bus.wr_adr[LANE_W-1:0];

    // Bank k sits one row further on when it lies below the start lane.
    for (genvar k = 0; k < BEAT_BYTES; k++) begin : g_bank
        logic [RF_W-1:0]   rrow, wrow;
        logic              win, we;
        logic [LANE_W-1:0] wsel;
        logic [ROW_W-1:0]  waddr;
        logic [7:0]        din;

        assign wbyte[k] = bus.wr_data[8*k +: 8];
        assign rrow = iss_adr[ADDR_W:LANE_W]
                    + RF_W'(LANE_W'(k) < rlane);
        assign wrow = {1'b0, bus.wr_adr[ADDR_W-1:LANE_W]}
                    + RF_W'(LANE_W'(k) < wlane);
        assign iss_mask[k] = (rrow < RF_W'(ROWS));
        assign win  = (wrow < RF_W'(ROWS));
        assign wsel = LANE_W'(lane_rot(k, BEAT_BYTES - 32'(wlane),
                                       BEAT_BYTES));
        assign we    = clr | (wr_fire & bus.wr_be[wsel] & win);
        assign waddr = clr ? clr_row : wrow[ROW_W-1:0];
        assign din   = clr ? 8'h00 : wbyte[wsel];

        vliw_ram_bank #(.ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
            .clk   (clk_h),
            .rst_n (rst_n),
            .re    (issue),
            .raddr (rrow[ROW_W-1:0]),
            .we    (we),
            .waddr (waddr),
            .din   (din),
            .dout  (dout[k])
        );
    end

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_lane  <= '0;
            rd_mask  <= '0;
        end else begin
            rd_valid <= issue;
            rd_last  <= issue & last;
            if (issue) begin
                rd_lane <= rlane;
                rd_mask <= iss_mask;
            end
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_last  = rd_last;

    for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_out
        logic [LANE_W-1:0] sel;
        assign sel = LANE_W'(lane_rot(j, 32'(rd_lane), BEAT_BYTES));
        assign bus.rd_data[8*j +: 8] = rd_mask[sel] ? dout[sel] : 8'h00;
    end
endmodule

// File: tb/tb_vliw_burst_ram.sv
// Scoreboard bench for vliw_burst_ram at 4-byte beats, 64-byte depth.
// Reads push expected beats; a negedge monitor pops and compares them.
module tb_vliw_burst_ram;
    localparam int BB = 4;
    localparam int DB = 64;
    localparam int AW = 16;
    localparam int LW = 2;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic clk_h = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb [$];
    int   vec  = 0;
    int   miss = 0;

    vliw_burst_ram_if #(.BEAT_BYTES(BB), .ADDR_W(AW), .LEN_W(LW)) bus ();

    vliw_burst_ram #(
        .BEAT_BYTES(BB), .DEPTH_BYTES(DB), .ADDR_W(AW), .LEN_W(LW)
    ) dut (
        .clk_h (clk_h),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk_h) begin
        if (rst_n && bus.rd_valid) begin
            vec++;
            if (sb.size() == 0) begin
                miss++;
                $display("FAIL unexpected_beat: got %h last %b want none",
                         bus.rd_data, bus.rd_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rd_data !== e.d || bus.rd_last !== e.l) begin
                    miss++;
                    $display("FAIL beat: got %h last %b want %h last %b",
                             bus.rd_data, bus.rd_last, e.d, e.l);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    // Releases reset and checks the sweep length and stalled readies.
    task automatic clear_check(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        @(posedge clk_h);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_h);
            if (!bus.busy) break;
            n++;
            if (bus.rd_req_ready || bus.wr_ready) bad++;
        end
        chk({tag, "_busy_cycles"}, n, 16);
        chk({tag, "_ready_during_clear"}, bad, 0);
        chk({tag, "_ready_after"}, {30'd0, bus.rd_req_ready, bus.wr_ready},
            32'd3);
        @(posedge clk_h);
        #1;
    endtask

    task automatic wr(input logic [15:0] adr, input logic [31:0] d,
                      input logic [3:0] be);
        bus.wr_valid = 1'b1;
        bus.wr_adr   = adr;
        bus.wr_data  = d;
        bus.wr_be    = be;
        @(posedge clk_h);
        #1 bus.wr_valid = 1'b0;
    endtask

    // Issues a burst, pushes its beats, returns cycles with ready low.
    task automatic rd(input logic [15:0] adr, input logic [1:0] len,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3,
                      output int lo);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 50 && !bus.rd_req_ready; i++) begin
            @(posedge clk_h);
            #1;
        end
        bus.rd_req_valid = 1'b1;
        bus.rd_adr       = adr;
        bus.rd_len       = len;
        for (int i = 0; i <= int'(len); i++) push(e[i], i == int'(len));
        @(posedge clk_h);
        #1 bus.rd_req_valid = 1'b0;
        lo = 0;
        while (!bus.rd_req_ready && lo < 20) begin
            lo++;
            @(posedge clk_h);
            #1;
        end
    endtask

    task automatic rd1(input logic [15:0] adr, input logic [31:0] e0);
        int lo;
        rd(adr, 2'd0, e0, 32'h0, 32'h0, 32'h0, lo);
    endtask

    task automatic drain();
        @(posedge clk_h);
        @(posedge clk_h);
        #1;
    endtask

    initial begin
        int lo;
        bus.rd_req_valid = 1'b0;
        bus.rd_adr       = '0;
        bus.rd_len       = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_adr       = '0;
        bus.wr_data      = '0;
        bus.wr_be        = '0;
        #2;
        chk("reset_busy", {31'd0, bus.busy}, 32'd1);
        chk("reset_readies", {30'd0, bus.rd_req_ready, bus.wr_ready}, 32'd0);
        chk("reset_rd_flags", {30'd0, bus.rd_valid, bus.rd_last}, 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        clear_check("clr1");
        rd1(16'd0, 32'h0000_0000);

        wr(16'd6, 32'hDDCC_BBAA, 4'b1111);
        rd1(16'd4, 32'hBBAA_0000);
        rd1(16'd8, 32'h0000_DDCC);

        for (int a = 0; a < 64; a += 4)
            wr(16'(a), {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)}, 4'b1111);
        rd(16'd2, 2'd3, 32'h0504_0302, 32'h0908_0706,
           32'h0D0C_0B0A, 32'h1110_0F0E, lo);
        chk("burst_ready_low", lo, 3);

        rd1(16'd62, 32'h0000_3F3E);
        wr(16'd62, 32'hA5A5_A5A5, 4'b1111);
        rd1(16'd0, 32'h0302_0100);
        rd1(16'd60, 32'hA5A5_3D3C);
        rd1(16'd62, 32'h0000_A5A5);

        // Collision: read and write of the same bytes on one edge.
        bus.rd_req_valid = 1'b1;
        bus.rd_adr       = 16'd0;
        bus.rd_len       = 2'd0;
        bus.wr_valid     = 1'b1;
        bus.wr_adr       = 16'd0;
        bus.wr_data      = 32'hFFFF_FFFF;
        bus.wr_be        = 4'b0101;
        push(32'h0302_0100, 1'b1);
        @(posedge clk_h);
        #1;
        bus.wr_valid     = 1'b0;
        bus.rd_adr       = 16'd0;
        push(32'h03FF_01FF, 1'b1);
        @(posedge clk_h);
        #1 bus.rd_req_valid = 1'b0;
        drain();

        // Reset lands during beat 2 of a len=3 burst.
        bus.rd_req_valid = 1'b1;
        bus.rd_adr       = 16'd16;
        bus.rd_len       = 2'd3;
        push(32'h1312_1110, 1'b0);
        push(32'h1716_1514, 1'b0);
        @(posedge clk_h);
        #1 bus.rd_req_valid = 1'b0;
        @(posedge clk_h);
        #8 rst_n = 1'b0;
        #1;
        chk("midrst_rd_flags", {30'd0, bus.rd_valid, bus.rd_last}, 32'd0);
        chk("midrst_rd_data", bus.rd_data, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd1);
        chk("midrst_pending", sb.size(), 0);
        clear_check("clr2");
        rd1(16'd16, 32'h0000_0000);
        rd1(16'd61, 32'h0000_0000);
        rd1(16'd2, 32'h0000_0000);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
